decode_stage_hs: RTL and testbench

//  Registered MIPS decode stage: takes a fetched 32-bit instruction via valid/ready, decodes
//  R/I/J formats into a one-entry control/field output register. Sits between fetch and the

---
 rtl/mips_defs_pkg.sv | 45 ++++
 rtl/mips_decode_comb.sv | 104 ++++++++++
 rtl/decode_stage_hs.sv | 139 +++++++++++++
 tb/tb_decode_stage_hs.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU codes and
// the small enumerations carried by the decoded control bundle.
package mips_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_OR    = 6'h25;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_SLT  = 4'd12;

    localparam logic [1:0] SRC_B_RT  = 2'd0;
    localparam logic [1:0] SRC_B_IMM = 2'd2;

    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
    typedef enum logic [1:0] {JS_NONE = 2'd0, JS_TARGET = 2'd1, JS_REG = 2'd2} jump_sel_e;
    typedef enum logic [1:0] {BR_NONE = 2'd0, BR_BEQ = 2'd1, BR_BNE = 2'd2} branch_e;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/mips_decode_comb.sv
// Pure combinational MIPS instruction decoder: raw word in, control/field bundle out.
module mips_decode_comb
    import mips_defs_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ALU_CTRL_W = 4
) (
    input  logic [DATA_W-1:0]     instr,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            dest_addr,
    output logic [4:0]            shamt,
    output logic [DATA_W-1:0]     imm_ext,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            src_b_sel,
    output logic [1:0]            wb_sel,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic [1:0]            jump_sel,
    output logic [1:0]            branch,
    output logic                  mult_start,
    output logic                  mflo_req,
    output logic                  illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    assign imm_ext = is_zext_op(opcode) ? {{(DATA_W-16){1'b0}}, imm16}
                                        : {{(DATA_W-16){imm16[15]}}, imm16};

    always_comb begin
        dest_addr   = rt;
        src_b_sel   = SRC_B_IMM;
        wb_sel      = WB_ALU;
        alu_control = ALU_CTRL_W'(ALU_NONE);
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        jump_sel    = JS_NONE;
        branch      = BR_NONE;
        mult_start  = 1'b0;
        mflo_req    = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dest_addr = rd;
                src_b_sel = SRC_B_RT;
                case (funct)
                    FN_SLL:  begin alu_control = ALU_CTRL_W'(ALU_SLL); reg_write = 1'b1; end
                    FN_JR:   jump_sel = JS_REG;
                    FN_MFLO: begin mflo_req = 1'b1; reg_write = 1'b1; end
                    FN_MULT: mult_start = 1'b1;
                    FN_ADD:  begin alu_control = ALU_CTRL_W'(ALU_ADD); reg_write = 1'b1; end
                    FN_OR:   begin alu_control = ALU_CTRL_W'(ALU_OR); reg_write = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_J:    jump_sel = JS_TARGET;
            OP_JAL: begin
                jump_sel  = JS_TARGET;
                dest_addr = 5'd31;
                wb_sel    = WB_PC4;
                reg_write = 1'b1;
            end
            OP_BEQ: begin alu_control = ALU_CTRL_W'(ALU_ADD); src_b_sel = SRC_B_RT; branch = BR_BEQ; end
            OP_BNE: begin alu_control = ALU_CTRL_W'(ALU_ADD); src_b_sel = SRC_B_RT; branch = BR_BNE; end
            OP_ADDI: begin alu_control = ALU_CTRL_W'(ALU_ADD); reg_write = 1'b1; end
            OP_SLTI: begin alu_control = ALU_CTRL_W'(ALU_SLT); reg_write = 1'b1; end
            OP_ANDI: begin alu_control = ALU_CTRL_W'(ALU_AND); reg_write = 1'b1; end
            OP_ORI:  begin alu_control = ALU_CTRL_W'(ALU_OR);  reg_write = 1'b1; end
            OP_LUI:  begin alu_control = ALU_CTRL_W'(ALU_LUI); reg_write = 1'b1; end
            OP_LW: begin
                alu_control = ALU_CTRL_W'(ALU_ADD);
                wb_sel      = WB_MEM;
                reg_write   = 1'b1;
            end
            OP_SW: begin alu_control = ALU_CTRL_W'(ALU_ADD); mem_write = 1'b1; end
            default: illegal = 1'b1;
        endcase
        // An illegal word carries no control side effects, only its raw fields.
        if (illegal) begin
            src_b_sel   = SRC_B_RT;
            wb_sel      = WB_ALU;
            alu_control = ALU_CTRL_W'(ALU_NONE);
            reg_write   = 1'b0;
            mem_write   = 1'b0;
            jump_sel    = JS_NONE;
            branch      = BR_NONE;
            mult_start  = 1'b0;
            mflo_req    = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage_hs.sv
// Registered MIPS decode stage with valid/ready handshake, multiplier busy
// sequencing and an mflo hazard stall with a saturating stall counter.
module decode_stage_hs
    import mips_defs_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int MULT_LATENCY = 4,
    parameter int ALU_CTRL_W   = 4,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             dest_addr,
    output logic [4:0]             shamt,
    output logic [DATA_W-1:0]      imm_ext,
    output logic [ALU_CTRL_W-1:0]  alu_control,
    output logic [1:0]             src_b_sel,
    output logic [1:0]             wb_sel,
    output logic                   reg_write,
    output logic                   mem_write,
    output logic [1:0]             jump_sel,
    output logic [1:0]             branch,
    output logic                   mult_start,
    output logic                   mflo_req,
    output logic                   illegal,
    output logic                   mult_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int CNT_W = 4;

    logic [4:0]            rs_p0, rt_p0, dest_p0, shamt_p0;
    logic [DATA_W-1:0]     imm_p0;
    logic [ALU_CTRL_W-1:0] alu_p0;
    logic [1:0]            src_b_p0, wb_p0, jump_p0, branch_p0;
    logic                  rw_p0, mw_p0, mult_p0, mflo_p0, illegal_p0;

    logic [CNT_W-1:0] mult_cnt;
    logic             hazard;
    logic             take;
    logic             mult_handoff;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    mips_decode_comb #(
        .DATA_W     (DATA_W),
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_dec (
        .instr       (instr),
        .rs          (rs_p0),
        .rt          (rt_p0),
        .dest_addr   (dest_p0),
        .shamt       (shamt_p0),
        .imm_ext     (imm_p0),
        .alu_control (alu_p0),
        .src_b_sel   (src_b_p0),
        .wb_sel      (wb_p0),
        .reg_write   (rw_p0),
        .mem_write   (mw_p0),
        .jump_sel    (jump_p0),
        .branch      (branch_p0),
        .mult_start  (mult_p0),
        .mflo_req    (mflo_p0),
        .illegal     (illegal_p0)
    );

    // The pending-mult term covers the cycle a mult hands off, before the counter has loaded.
    assign hazard       = in_valid & mflo_p0 & ((mult_cnt != '0) | (out_valid & mult_start));
    assign in_ready     = (~out_valid | out_ready) & ~hazard;
    assign take         = in_valid & in_ready;
    assign mult_handoff = out_valid & out_ready & mult_start;
    assign mult_busy    = (mult_cnt != '0);

    // ---- stage p0 -> p1: output bundle register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            rs          <= '0;
            rt          <= '0;
            dest_addr   <= '0;
            shamt       <= '0;
            imm_ext     <= '0;
            alu_control <= '0;
            src_b_sel   <= '0;
            wb_sel      <= '0;
            reg_write   <= 1'b0;
            mem_write   <= 1'b0;
            jump_sel    <= '0;
            branch      <= '0;
            mult_start  <= 1'b0;
            mflo_req    <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            if (~out_valid | out_ready)
                out_valid <= take;
            if (take) begin
                rs          <= rs_p0;
                rt          <= rt_p0;
                dest_addr   <= dest_p0;
                shamt       <= shamt_p0;
                imm_ext     <= imm_p0;
                alu_control <= alu_p0;
                src_b_sel   <= src_b_p0;
                wb_sel      <= wb_p0;
                reg_write   <= rw_p0;
                mem_write   <= mw_p0;
                jump_sel    <= jump_p0;
                branch      <= branch_p0;
                mult_start  <= mult_p0;
                mflo_req    <= mflo_p0;
                illegal     <= illegal_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mult_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (mult_handoff)
                mult_cnt <= CNT_W'(MULT_LATENCY);
            else if (mult_cnt != '0)
                mult_cnt <= mult_cnt - 1'b1;
            if (hazard)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: decode vector table plus handshake,
// mult/mflo hazard, stall-counter saturation and reset sequences.
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rs, rt, dest_addr, shamt;
    logic [31:0] imm_ext;
    logic [3:0]  alu_control;
    logic [1:0]  src_b_sel, wb_sel, jump_sel, branch;
    logic        reg_write, mem_write, mult_start, mflo_req, illegal, mult_busy;
    logic [2:0]  stall_cnt;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    decode_stage_hs #(
        .DATA_W       (32),
        .MULT_LATENCY (4),
        .ALU_CTRL_W   (4),
        .STALL_CNT_W  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rs          (rs),
        .rt          (rt),
        .dest_addr   (dest_addr),
        .shamt       (shamt),
        .imm_ext     (imm_ext),
        .alu_control (alu_control),
        .src_b_sel   (src_b_sel),
        .wb_sel      (wb_sel),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .jump_sel    (jump_sel),
        .branch      (branch),
        .mult_start  (mult_start),
        .mflo_req    (mflo_req),
        .illegal     (illegal),
        .mult_busy   (mult_busy),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [19:0] fld;
        logic [16:0] ctrl;
        logic [31:0] imm;
    } vec_t;

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_OR   = 32'h00A62025;
    localparam logic [31:0] I_LUI  = 32'h3C021234;
    localparam logic [31:0] I_MULT = 32'h00220018;
    localparam logic [31:0] I_MFLO = 32'h00001012;

    function automatic logic [19:0] f(input int r_s, input int r_t, input int d, input int sh);
        return {5'(r_s), 5'(r_t), 5'(d), 5'(sh)};
    endfunction

    function automatic logic [16:0] mk(input int alu, input int sb, input int wb, input int rw,
                                       input int mw, input int js, input int br, input int ms,
                                       input int mf, input int il);
        return {4'(alu), 2'(sb), 2'(wb), 1'(rw), 1'(mw), 2'(js), 2'(br), 1'(ms), 1'(mf), 1'(il)};
    endfunction

    function automatic logic [16:0] act_ctrl();
        return {alu_control, src_b_sel, wb_sel, reg_write, mem_write, jump_sel, branch,
                mult_start, mflo_req, illegal};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int held);
        held = 0;
        #1;
        while (!in_ready && held < 20) begin
            tick();
            held++;
        end
    endtask

    vec_t vecs[19];
    int   held;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0;

        vecs[0]  = '{"add",    32'h00221820, f(1,2,3,0),   mk(2,0,0,1,0,0,0,0,0,0),  32'h00001820};
        vecs[1]  = '{"andi",   32'h3128FFFF, f(9,8,8,31),  mk(5,2,0,1,0,0,0,0,0,0),  32'h0000FFFF};
        vecs[2]  = '{"addi",   32'h2128FFFF, f(9,8,8,31),  mk(2,2,0,1,0,0,0,0,0,0),  32'hFFFFFFFF};
        vecs[3]  = '{"jal",    32'h0C000100, f(0,0,31,4),  mk(0,2,2,1,0,1,0,0,0,0),  32'h00000100};
        vecs[4]  = '{"op3f",   32'hFC000000, f(0,0,0,0),   mk(0,0,0,0,0,0,0,0,0,1),  32'h00000000};
        vecs[5]  = '{"sll",    32'h00031100, f(0,3,2,4),   mk(8,0,0,1,0,0,0,0,0,0),  32'h00001100};
        vecs[6]  = '{"jr",     32'h03E00008, f(31,0,0,0),  mk(0,0,0,0,0,2,0,0,0,0),  32'h00000008};
        vecs[7]  = '{"or",     32'h00A62025, f(5,6,4,0),   mk(6,0,0,1,0,0,0,0,0,0),  32'h00002025};
        vecs[8]  = '{"beq",    32'h1022FFFF, f(1,2,2,31),  mk(2,0,0,0,0,0,1,0,0,0),  32'hFFFFFFFF};
        vecs[9]  = '{"bne",    32'h1422FFFF, f(1,2,2,31),  mk(2,0,0,0,0,0,2,0,0,0),  32'hFFFFFFFF};
        vecs[10] = '{"slti",   32'h28228000, f(1,2,2,0),   mk(12,2,0,1,0,0,0,0,0,0), 32'hFFFF8000};
        vecs[11] = '{"ori",    32'h34228000, f(1,2,2,0),   mk(6,2,0,1,0,0,0,0,0,0),  32'h00008000};
        vecs[12] = '{"lui",    32'h3C021234, f(0,2,2,8),   mk(11,2,0,1,0,0,0,0,0,0), 32'h00001234};
        vecs[13] = '{"lw",     32'h8C22FFFC, f(1,2,2,31),  mk(2,2,1,1,0,0,0,0,0,0),  32'hFFFFFFFC};
        vecs[14] = '{"sw",     32'hAC22FFFC, f(1,2,2,31),  mk(2,2,0,0,1,0,0,0,0,0),  32'hFFFFFFFC};
        vecs[15] = '{"j",      32'h08000040, f(0,0,0,1),   mk(0,2,0,0,0,1,0,0,0,0),  32'h00000040};
        vecs[16] = '{"fn3f",   32'h0000003F, f(0,0,0,0),   mk(0,0,0,0,0,0,0,0,0,1),  32'h0000003F};
        vecs[17] = '{"mflo",   32'h00001012, f(0,0,2,0),   mk(0,0,0,1,0,0,0,0,1,0),  32'h00001012};
        vecs[18] = '{"mult",   32'h00220018, f(1,2,0,0),   mk(0,0,0,0,0,0,0,1,0,0),  32'h00000018};

        tick();
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mult_busy", 64'(mult_busy), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Decode table at full throughput: one instruction per cycle.
        for (int i = 0; i < 19; i++) begin
            instr = vecs[i].instr;
            in_valid = 1'b1;
            #1;
            chk({vecs[i].name, "_in_ready"}, 64'(in_ready), 64'd1);
            tick();
            chk({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
            chk({vecs[i].name, "_fields"}, 64'({rs, rt, dest_addr, shamt}), 64'(vecs[i].fld));
            chk({vecs[i].name, "_ctrl"}, 64'(act_ctrl()), 64'(vecs[i].ctrl));
            chk({vecs[i].name, "_imm"}, 64'(imm_ext), 64'(vecs[i].imm));
        end
        in_valid = 1'b0;
        tick();
        do_reset();

        // Backpressure: bundle held stable, no loss, no duplication.
        instr = I_ADD; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        instr = I_OR; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_dest", 64'(dest_addr), 64'd3);
            chk("hold_ctrl", 64'(act_ctrl()), 64'(mk(2,0,0,1,0,0,0,0,0,0)));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("stream_b_dest", 64'(dest_addr), 64'd4);
        chk("stream_b_alu", 64'(alu_control), 64'd6);
        instr = I_LUI;
        tick();
        chk("stream_c_dest", 64'(dest_addr), 64'd2);
        chk("stream_c_alu", 64'(alu_control), 64'd11);
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", 64'(out_valid), 64'd0);

        // mflo arriving after the mult has handed off waits out the counter.
        do_reset();
        instr = I_MULT; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mult_busy_after_handoff", 64'(mult_busy), 64'd1);
        instr = I_MFLO; in_valid = 1'b1;
        wait_ready(held);
        chk("mflo_held_cycles", 64'(held), 64'd4);
        chk("mflo_stall_cnt", 64'(stall_cnt), 64'd4);
        chk("mflo_busy_clear", 64'(mult_busy), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("mflo_accepted", 64'({out_valid, mflo_req, dest_addr}), 64'({1'b1, 1'b1, 5'd2}));

        // mflo right behind a mult still in the output register, then saturation.
        do_reset();
        instr = I_MULT; in_valid = 1'b1;
        tick();
        instr = I_MFLO;
        #1;
        chk("simul_blocked", 64'(in_ready), 64'd0);
        wait_ready(held);
        chk("simul_held_cycles", 64'(held), 64'd5);
        chk("simul_stall_cnt", 64'(stall_cnt), 64'd5);
        tick();
        instr = I_MULT;
        tick();
        instr = I_MFLO;
        wait_ready(held);
        chk("sat_held_cycles", 64'(held), 64'd5);
        chk("sat_stall_cnt", 64'(stall_cnt), 64'd7);
        tick();
        in_valid = 1'b0;
        chk("sat_mflo_out", 64'(mflo_req), 64'd1);

        // Reset while the multiplier is busy and a bundle is pending.
        do_reset();
        instr = I_MULT; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        instr = I_ADD; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk("pre_reset_busy", 64'(mult_busy), 64'd1);
        chk("pre_reset_pending", 64'(out_valid), 64'd1);
        reset = 1'b1; instr = I_MFLO; in_valid = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_reset_busy", 64'(mult_busy), 64'd0);
        chk("post_reset_valid", 64'(out_valid), 64'd0);
        chk("post_reset_bundle", 64'({dest_addr, act_ctrl()}), 64'd0);
        chk("post_reset_imm", 64'(imm_ext), 64'd0);
        chk("post_reset_stall", 64'(stall_cnt), 64'd0);
        chk("post_reset_mflo_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_reset_mflo_out", 64'({out_valid, mflo_req}), 64'({1'b1, 1'b1}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
